bram_stream_reader: RTL and testbench

Streams a contiguous block of words from the single-port 16-bit block RAM onto a valid/ready output stream. It sits directly downstream of the RAM: it drives the RAM address port and consumes the RAM's registered read data. It hides the RAM's one-cycle read latency behind a 2-entry output buffer, so that a consumer with `out_ready` held high receives one word per cycle. It only reads, and ties the RAM write-enable low while it owns the port.

---
 rtl/bram_stream_reader_if.sv | 13 +
 rtl/bram_stream_reader.sv | 143 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Valid/ready output stream carrying words read out of block RAM.
// The master drives data/valid/last; the slave returns ready.
interface bram_stream_reader_if #(
  parameter int WORDSIZE = 16
);
  logic [WORDSIZE-1:0] out_data;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Streams a contiguous block of RAM words onto a valid/ready stream, hiding the
// RAM's one-cycle read latency behind a 2-entry output FIFO with credit-based issue.
module bram_stream_reader #(
  parameter int ADDRSIZE = 13,
  parameter int WORDSIZE = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDRSIZE-1:0] base_addr,
  input  logic [ADDRSIZE:0]   length,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [ADDRSIZE-1:0] bram_addr,
  output logic                bram_we,
  input  logic [WORDSIZE-1:0] bram_rdata,
  bram_stream_reader_if.master stream
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] rd_ptr;
  logic [ADDRSIZE:0]   issue_cnt;
  logic [ADDRSIZE:0]   beat_cnt;
  logic                in_flight;
  logic [WORDSIZE-1:0] fifo_mem [2];
  logic                wr_idx;
  logic                rd_idx;
  logic [1:0]          fifo_cnt;
  logic                done_q;

  logic fifo_valid;
  logic pop;
  logic issue;
  logic last_beat;
  logic start_go;
  logic start_zero;

  assign fifo_valid = (fifo_cnt != 2'd0);
  assign pop        = fifo_valid && stream.out_ready;
  assign last_beat  = pop && (beat_cnt == (ADDRSIZE+1)'(1));
  assign start_go   = (state_q == IDLE) && start && !abort && (length != '0);
  assign start_zero = (state_q == IDLE) && start && !abort && (length == '0);

  // Credit: words held plus the one in flight, less the one leaving, must leave room.
  assign issue = (state_q == READ) && (issue_cnt != '0) &&
                 (({1'b0, fifo_cnt} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop}));

  // State register
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_go) state_d = READ;
        READ:    if (issue && (issue_cnt == (ADDRSIZE+1)'(1))) state_d = DRAIN;
        DRAIN:   if (last_beat) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy    = (state_q != IDLE);
    bram_we = 1'b0;
  end

  // Datapath: read pointer, counters, in-flight tracking and output FIFO.
  // NOTE: the two FIFO entries are reset because the head drives out_data,
  // which must read 0 out of reset; larger memories would normally not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      issue_cnt   <= '0;
      beat_cnt    <= '0;
      in_flight   <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_idx      <= 1'b0;
      rd_idx      <= 1'b0;
      fifo_cnt    <= 2'd0;
      done_q      <= 1'b0;
    end else if (abort) begin
      issue_cnt <= '0;
      beat_cnt  <= '0;
      in_flight <= 1'b0;
      wr_idx    <= 1'b0;
      rd_idx    <= 1'b0;
      fifo_cnt  <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= start_zero || ((state_q == DRAIN) && last_beat);

      if (start_go) begin
        rd_ptr    <= base_addr;
        issue_cnt <= length;
        beat_cnt  <= length;
      end else begin
        if (issue) begin
          rd_ptr    <= rd_ptr + ADDRSIZE'(1);
          issue_cnt <= issue_cnt - (ADDRSIZE+1)'(1);
        end
        if (pop) beat_cnt <= beat_cnt - (ADDRSIZE+1)'(1);
      end

      in_flight <= issue;

      // The RAM's registered data is valid exactly one cycle after issue.
      if (in_flight) begin
        fifo_mem[wr_idx] <= bram_rdata;
        wr_idx           <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;

      unique case ({in_flight, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign bram_addr        = rd_ptr;
  assign done             = done_q;
  assign stream.out_data  = fifo_mem[rd_idx];
  assign stream.out_valid = fifo_valid;
  assign stream.out_last  = fifo_valid && (beat_cnt == (ADDRSIZE+1)'(1));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: directed transfers push expected beats,
// a negedge monitor pops and compares every beat the DUT presents.
module tb_bram_stream_reader;

  localparam int ADDRSIZE = 13;
  localparam int WORDSIZE = 16;

  typedef struct {
    logic [WORDSIZE-1:0] data;
    logic                last;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [ADDRSIZE-1:0] base_addr;
  logic [ADDRSIZE:0]   length;
  logic                abort;
  logic                busy;
  logic                done;
  logic [ADDRSIZE-1:0] bram_addr;
  logic                bram_we;
  logic [WORDSIZE-1:0] bram_rdata;

  bram_stream_reader_if #(.WORDSIZE(WORDSIZE)) sif ();

  bram_stream_reader #(.ADDRSIZE(ADDRSIZE), .WORDSIZE(WORDSIZE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bram_addr  (bram_addr),
    .bram_we    (bram_we),
    .bram_rdata (bram_rdata),
    .stream     (sif.master)
  );

  always #5 clk = ~clk;

  // Block RAM model: registered read, mem[i] = i + 0x100.
  logic [WORDSIZE-1:0] mem [1 << ADDRSIZE];
  initial for (int i = 0; i < (1 << ADDRSIZE); i++) mem[i] = WORDSIZE'(i + 'h100);
  always @(posedge clk) bram_rdata <= mem[bram_addr];

  int    n_checks = 0;
  int    n_fail   = 0;
  int    beats_seen = 0;
  bit    stall_chk_en = 1'b0;
  bit    prev_stall = 1'b0;
  logic [WORDSIZE-1:0] prev_data;
  beat_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WORDSIZE-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic issue_start(input int base, input int len);
    start     = 1'b1;
    base_addr = ADDRSIZE'(base);
    length    = (ADDRSIZE+1)'(len);
    tick();
    start     = 1'b0;
  endtask

  // Waits for done, optionally driving the 1,0,0 ready pattern; returns cycles waited.
  task automatic wait_done(input int budget, input bit bp, output int cycles);
    bit found = 1'b0;
    int phase = 0;
    cycles = 0;
    for (int i = 0; i < budget && !found; i++) begin
      if (bp) begin
        sif.out_ready = (phase == 0);
        phase = (phase + 1) % 3;
      end
      tick();
      cycles++;
      if (done) found = 1'b1;
    end
    check("done_within_budget", found, 1);
  endtask

  // Monitor: values at the negedge describe the beat that transfers on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("fifo_count_le_2", dut.fifo_cnt <= 2'd2, 1);
      check("bram_we_low", bram_we, 0);
      if (stall_chk_en && prev_stall) begin
        check("stall_valid_held", sif.out_valid, 1);
        check("stall_data_held", sif.out_data, prev_data);
      end
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_data  = sif.out_data;
      if (!sif.out_valid) check("last_without_valid", sif.out_last, 0);
      if (sif.out_valid && sif.out_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat at %0t", sif.out_data, $time);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", sif.out_data, e.data);
          check("beat_last", sif.out_last, e.last);
        end
      end
    end
  end

  task automatic basic_stream();
    sif.out_ready = 1'b1;
    push(16'h0100, 1'b0);
    push(16'h0101, 1'b0);
    push(16'h0102, 1'b0);
    push(16'h0103, 1'b1);
    issue_start(0, 4);                     // now just after E0
    check("basic_busy_after_e0", busy, 1);
    check("basic_valid_after_e0", sif.out_valid, 0);
    tick();                                // E1
    check("basic_valid_after_e1", sif.out_valid, 0);
    tick();                                // E2
    check("basic_valid_after_e2", sif.out_valid, 1);
    tick(); tick(); tick();                // E3..E5
    check("basic_done_before_last", done, 0);
    tick();                                // E6: last beat transferred
    check("basic_done_pulse", done, 1);
    check("basic_busy_with_done", busy, 0);
    tick();
    check("basic_done_one_cycle", done, 0);
    check("basic_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; abort = 1'b0;
    sif.out_ready = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", sif.out_valid, 0);
    check("rst_last", sif.out_last, 0);
    check("rst_data", sif.out_data, 0);
    check("rst_addr", bram_addr, 0);
    #20 rst_n = 1'b1;
    tick();

    // Basic stream
    basic_stream();

    // Wrap-around: 8190, 8191, 0, 1
    push(16'h20FE, 1'b0);
    push(16'h20FF, 1'b0);
    push(16'h0100, 1'b0);
    push(16'h0101, 1'b1);
    issue_start(8190, 4);
    wait_done(30, 1'b0, cyc);
    check("wrap_done_latency", cyc, 6);
    check("wrap_queue_empty", exp_q.size(), 0);
    tick();

    // Backpressure with ready pattern 1,0,0
    stall_chk_en = 1'b1;
    for (int i = 0; i < 8; i++) push(WORDSIZE'('h180 + i), i == 7);
    issue_start('h80, 8);
    wait_done(200, 1'b1, cyc);
    check("bp_queue_empty", exp_q.size(), 0);
    stall_chk_en = 1'b0;
    sif.out_ready = 1'b1;
    tick();

    // Zero length
    issue_start(5, 0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_valid", sif.out_valid, 0);
    tick();
    check("zero_done_one_cycle", done, 0);
    check("zero_valid_after", sif.out_valid, 0);

    // Start while busy is ignored
    push(16'h0110, 1'b0);
    push(16'h0111, 1'b0);
    push(16'h0112, 1'b1);
    issue_start('h10, 3);
    tick();
    issue_start('h200, 5);
    wait_done(30, 1'b0, cyc);
    check("busy_start_queue_empty", exp_q.size(), 0);
    repeat (6) tick();
    check("busy_start_idle", busy, 0);

    // Abort after 3 beats of a 16-word transfer
    beats_seen = 0;
    for (int i = 0; i < 16; i++) push(WORDSIZE'('h100 + i), i == 15);
    issue_start(0, 16);
    for (int i = 0; i < 40 && beats_seen < 3; i++) tick();
    check("abort_three_beats", beats_seen, 3);
    abort = 1'b1;
    sif.out_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", sif.out_valid, 0);
    check("abort_no_done", done, 0);
    exp_q.delete();
    tick();
    check("abort_no_done_later", done, 0);
    check("abort_valid_later", sif.out_valid, 0);
    sif.out_ready = 1'b1;
    push(16'h0140, 1'b0);
    push(16'h0141, 1'b1);
    issue_start('h40, 2);
    wait_done(20, 1'b0, cyc);
    check("post_abort_queue_empty", exp_q.size(), 0);
    tick();

    // Reset during READ with the FIFO full
    sif.out_ready = 1'b0;
    issue_start(0, 16);
    repeat (4) tick();
    check("pre_reset_busy", busy, 1);
    check("pre_reset_fifo_full", dut.fifo_cnt, 2);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", sif.out_valid, 0);
    check("async_rst_last", sif.out_last, 0);
    check("async_rst_data", sif.out_data, 0);
    check("async_rst_addr", bram_addr, 0);
    check("async_rst_done", done, 0);
    check("async_rst_we", bram_we, 0);
    exp_q.delete();
    #12 rst_n = 1'b1;
    tick();
    basic_stream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
